// File: rtl/adder_tree_sequencer.sv
// ---------------------------------------------------------------------------
// adder_tree_sequencer
//
// Computes popcount(spikes & weights) over an N_IN-bit vector by reusing one
// combinational adder tree (CHUNK = 2**(N_STAGE+1) inputs) over N_CHUNKS
// consecutive cycles, accumulating the partial counts.
//
// Parameters
//   N_STAGE   adder tree depth; CHUNK = 2**(N_STAGE+1) bits per chunk
//   N_CHUNKS  chunks per update; N_IN = CHUNK*N_CHUNKS
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   spikes     N_IN-bit presynaptic spike vector
//   weights    N_IN-bit binary weights
//   in_valid   spikes/weights valid
//   in_ready   high only in IDLE
//   sum        SUM_W-bit result, held stable while out_valid is high
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts the result
//   busy       high in any state other than IDLE
//   dbg_state  current FSM state (IDLE=0, ACCUM=1, DONE=2)
//
// Handshake: a transfer occurs on a rising edge where valid and ready are both
// high; valid never depends on ready, and a producer holding valid keeps its
// payload stable until the transfer.
//
// Feature macro SEQ_PIPE_EN: registers the tree output before the
// accumulator; ACCUM then lasts N_CHUNKS+1 cycles (first cycle fills the
// pipeline register). Default build (macro undefined) is fully combinational
// from tree to accumulator.
// ---------------------------------------------------------------------------
module adder_tree_sequencer #(
    parameter int N_STAGE  = 2,
    parameter int N_CHUNKS = 4,
    localparam int CHUNK   = 2 ** (N_STAGE + 1),
    localparam int N_IN    = CHUNK * N_CHUNKS,
    localparam int SUM_W   = $clog2(N_IN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  spikes,
    input  logic [N_IN-1:0]  weights,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SUM_W-1:0] sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int TREE_W = N_STAGE + 2;  // popcount of CHUNK bits
    localparam int CNT_W  = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [N_IN-1:0]   r_operand;
    logic [SUM_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [CHUNK-1:0]  w_chunk;
    logic [TREE_W-1:0] w_tree;
    logic              w_last;

`ifdef SEQ_PIPE_EN
    logic [TREE_W-1:0] r_tree;
    logic              r_pipe_vld;  // r_tree holds a real chunk count
    logic              r_tail;      // last chunk issued, draining r_tree
`endif

    // ------------------------------------------------------------------
    // Adder tree: leaf level adds bit pairs, then N_STAGE pairwise levels.
    // ------------------------------------------------------------------
    assign w_chunk = r_operand[CHUNK*r_cnt +: CHUNK];

    for (genvar l = 0; l <= N_STAGE; l++) begin : g_lvl
        localparam int NODES = CHUNK >> (l + 1);
        logic [TREE_W-1:0] w_node [NODES];
        for (genvar i = 0; i < NODES; i++) begin : g_node
            if (l == 0) begin : g_leaf
                assign w_node[i] = TREE_W'(w_chunk[2*i]) + TREE_W'(w_chunk[2*i+1]);
            end else begin : g_add
                assign w_node[i] = g_lvl[l-1].w_node[2*i] + g_lvl[l-1].w_node[2*i+1];
            end
        end
    end

    assign w_tree = g_lvl[N_STAGE].w_node[0];
    assign w_last = (r_cnt == LAST_CHUNK);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (in_valid) w_next = ACCUM;
`ifdef SEQ_PIPE_EN
            ACCUM: if (r_tail) w_next = DONE;
`else
            ACCUM: if (w_last) w_next = DONE;
`endif
            DONE:  if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
        dbg_state = r_state;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_operand <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
`ifdef SEQ_PIPE_EN
            r_tree     <= '0;
            r_pipe_vld <= 1'b0;
            r_tail     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_operand <= spikes & weights;
                        r_acc     <= '0;
                        r_cnt     <= '0;
`ifdef SEQ_PIPE_EN
                        r_tree     <= '0;
                        r_pipe_vld <= 1'b0;
                        r_tail     <= 1'b0;
`endif
                    end
                end
                ACCUM: begin
`ifdef SEQ_PIPE_EN
                    r_tree     <= w_tree;
                    r_pipe_vld <= 1'b1;
                    if (r_pipe_vld) r_acc <= r_acc + SUM_W'(r_tree);
                    // Counter freezes at 0 once the last chunk has been issued.
                    if (!r_tail) begin
                        r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
                        r_tail <= w_last;
                    end
`else
                    r_acc <= r_acc + SUM_W'(w_tree);
                    r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
`endif
                end
                default: ;  // DONE holds the result
            endcase
        end
    end

    assign sum = r_acc;

endmodule

// File: tb/tb_adder_tree_sequencer.sv
module tb_adder_tree_sequencer;

  localparam int N_IN  = 32;
  localparam int SUM_W = 6;
`ifdef SEQ_PIPE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  typedef struct {
    logic [N_IN-1:0] spikes;
    logic [N_IN-1:0] weights;
    int              exp_sum;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_IN-1:0]  spikes;
  logic [N_IN-1:0]  weights;
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] sum;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [1:0]       dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  adder_tree_sequencer dut (
    .clk(clk), .reset(reset), .spikes(spikes), .weights(weights),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .dbg_state(dbg_state)
  );

  // scoreboard
  logic [SUM_W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: popcount of the AND of the operands
  function automatic int ref_sum(input logic [N_IN-1:0] s, input logic [N_IN-1:0] w);
    int c = 0;
    for (int i = 0; i < N_IN; i++) c += int'(s[i] & w[i]);
    return c;
  endfunction

  // driver: present an input at a negedge; accepted at the following posedge
  task automatic start(input logic [N_IN-1:0] s, input logic [N_IN-1:0] w);
    @(negedge clk);
    check("in_ready_before_accept", int'(in_ready), 1);
    spikes   = s;
    weights  = w;
    in_valid = 1'b1;
    exp_q.push_back(SUM_W'(ref_sum(s, w)));
    @(posedge clk);
  endtask

  // wait for out_valid after acceptance; scrambles operands meanwhile
  task automatic wait_out(input bit hold_valid, input string tag);
    int cyc = 0;
    logic [SUM_W-1:0] exp;
    do begin
      @(negedge clk);
      cyc++;
      in_valid = hold_valid;
      spikes   = $urandom;
      weights  = $urandom;
    end while (!out_valid && cyc < 20);
    in_valid = 1'b0;
    exp = exp_q.pop_front();
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_sum"}, int'(sum), int'(exp));
  endtask

  // after a handshake with out_ready=1: back in IDLE, out_valid dropped
  task automatic check_released(input string tag);
    @(negedge clk);
    check({tag, "_out_valid_low"}, int'(out_valid), 0);
    check({tag, "_in_ready_high"}, int'(in_ready), 1);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32};
    tbl[1] = '{32'h0000_00FF, 32'hFFFF_FFFF, 8};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 0};
    tbl[3] = '{32'h8000_0001, 32'h8000_0001, 2};
    tbl[4] = '{32'h0F0F_0F0F, 32'hFF00_FF00, 8};
    tbl[5] = '{32'hAAAA_AAAA, 32'h5555_FFFF, 8};

    reset = 1'b1; spikes = '0; weights = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_sum", int'(sum), 0);

    // table-driven vectors; the table's expected value is checked too
    foreach (tbl[i]) begin
      start(tbl[i].spikes, tbl[i].weights);
      check($sformatf("tbl%0d_model", i), int'(exp_q[$]), tbl[i].exp_sum);
      wait_out(1'b0, $sformatf("tbl%0d", i));
      check_released($sformatf("tbl%0d", i));
    end

    // in_valid held high with changing operands during ACCUM
    start(32'h1234_5678, 32'hFFFF_0000);
    wait_out(1'b1, "holdvalid");
    check_released("holdvalid");

    // backpressure in DONE
    start(32'hF0F0_F0F0, 32'hFFFF_FFFF);
    out_ready = 1'b0;
    wait_out(1'b0, "bp");
    begin
      int s0;
      s0 = int'(sum);
      in_valid = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check("bp_out_valid_held", int'(out_valid), 1);
        check("bp_sum_held", int'(sum), s0);
        check("bp_in_ready_low", int'(in_ready), 0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    check_released("bp");
    // new input accepted only now
    spikes = 32'h0000_FFFF; weights = 32'h0000_0F0F;
    exp_q.push_back(SUM_W'(ref_sum(spikes, weights)));
    in_valid = 1'b1;
    @(posedge clk);
    wait_out(1'b0, "bp_next");
    check_released("bp_next");

    // reset during the 2nd ACCUM cycle discards the update
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    void'(exp_q.pop_back());
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_sum", int'(sum), 0);
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_in_ready", int'(in_ready), 1);
    start(32'h0000_0003, 32'h0000_0007);
    wait_out(1'b0, "rst_after");
    check_released("rst_after");

    // randomized updates against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [N_IN-1:0] s, w;
      s = $urandom;
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w = '1;
      start(s, w);
      wait_out(1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
      check_released($sformatf("rnd%0d", n));
    end

    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
